mode_select_fsm: RTL and testbench
==================================

# mode_select_fsm

Parametrised mode selector for the piano top level. It debounces an N-bit one-hot mode-switch bank and commits at most one active mode. Commits are deferred while the player engine reports busy, and the block recovers cleanly from invalid switch combinations. It drives the mode-enable bus consumed by the free-play, auto-play and learning engines, plus the mode LEDs.

## Interface
- NUM_MODES, 3, number of modes / switch bits, >= 2
- STABLE_CYCLES, 4, consecutive identical samples required before an input is settled, >= 1
- BLINK_HALF_PERIOD, 25_000_000, LED half-period in ERROR (used only with MODE_ERR_BLINK_EN)
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- x_in  in  NUM_MODES  mode switches, bit i selects mode i, already synchronised
- busy  in  1  engine busy; defers mode commits while high
- mode  out  NUM_MODES  committed one-hot mode, 0 = no mode
- mode_led  out  NUM_MODES  LED drive
- mode_valid  out  1  mode != 0
- mode_change  out  1  one-cycle pulse in the cycle `mode` takes a new value
- pending  out  1  a settled change is waiting for busy to drop
- error  out  1  in ERROR state
- state  out  2  FSM state: NONE=00, ACTIVE=01, PENDING=10, ERROR=11

## Operation
- Sampler: register s[NUM_MODES], counter cnt of width $clog2(STABLE_CYCLES+1).
  - If x_in != s: s<=x_in, cnt<=1.
  - Else: cnt increments, saturating at STABLE_CYCLES.
  - settled = (cnt == STABLE_CYCLES). A settled value is classified as VALID (exactly one bit set), ZERO, or MULTI.
- Settled MULTI in any state: go to ERROR and clear `mode` immediately, ignoring busy.
- NONE (`mode` = 0): settled VALID commits `mode` <= s and goes to ACTIVE. busy is ignored in NONE.
- ACTIVE, settled VALID equal to `mode`: stay.
- ACTIVE, settled VALID != `mode` or settled ZERO:
  - busy=0: commit immediately; ZERO goes to NONE, VALID stays ACTIVE.
  - busy=1: latch pend_r <= s and go to PENDING.
- PENDING, settled value equal to pend_r:
  - busy=0: commit pend_r; goes to NONE if pend_r = 0, else ACTIVE.
  - busy=1: stay.
- PENDING, settled value equals `mode`: cancel, return to ACTIVE, no change.
- PENDING, any other settled VALID/ZERO: pend_r <= s, stay.
- PENDING, unsettled input: hold pend_r.
- ERROR: settled ZERO goes to NONE; settled VALID commits and goes to ACTIVE (busy ignored); settled MULTI stays.
- Output assignments: mode_valid = |mode. pending = (state == PENDING). error = (state == ERROR).
- mode_change is registered and asserts in the first cycle a new `mode` value is visible, including clears on ERROR or NONE entry.
- Reset values: state=NONE, mode=0, s=0, cnt=0, pend_r=0, all outputs 0.
  - After reset, an all-zero input settles as ZERO, so NONE is held.
- Mid-operation reset takes effect at the next edge regardless of state or pending commit.

## Timing
- Input V first sampled at edge t (differs from s): cnt=1 after t, cnt=STABLE_CYCLES after edge t+STABLE_CYCLES-1.
- FSM acts at edge t+STABLE_CYCLES, so `mode` and mode_change are visible after that edge: latency STABLE_CYCLES+1 edges.
- A glitch shorter than STABLE_CYCLES samples never reaches the FSM. Any change restarts cnt at 1.
- PENDING commit occurs at the first edge sampling busy=0 with a settled input equal to pend_r. `mode` updates after that edge.
- In one cycle, settled MULTI outranks the busy check; reset outranks everything.

## Configuration
- MODE_ERR_BLINK_EN defined:
  - In ERROR, mode_led = all ones, toggling every BLINK_HALF_PERIOD cycles.
  - Starts on at ERROR entry; the blink counter resets on entry and on rst.
  - Outside ERROR, mode_led = mode.
- Not defined: mode_led = mode always (all zeros in ERROR). No blink counter is synthesised.

## Test plan
- Reset, then x_in=3'b010 held with STABLE_CYCLES=4 -> mode=010 and mode_change=1 exactly 5 edges after first sampling; state=01.
- With mode=001, drive x_in=3'b100 for 3 cycles, then back to 001 -> no change, no mode_change, state stays ACTIVE.
- With mode=001, busy=1, x_in=3'b100 settled -> pending=1, mode=001. Drop busy -> mode=100 and mode_change at the first busy=0 edge.
- From PENDING (pend_r=100), x_in returns to 001 and settles -> state ACTIVE, pending=0, mode=001.
- x_in=3'b011 settled while busy=1 -> error=1, mode=000, mode_change pulse. Then x_in=3'b100 settled -> mode=100, ACTIVE.
- With MODE_ERR_BLINK_EN, BLINK_HALF_PERIOD=3, in ERROR -> mode_led toggles 111/000 every 3 cycles. Assert rst mid-ERROR -> all outputs 0 next edge.

Source files
------------

// File: rtl/mode_select_fsm_if.sv
// Mode-selector bus: debounced switch inputs, busy handshake and committed-mode outputs.
interface mode_select_fsm_if #(
    parameter int NUM_MODES = 3
);
    logic [NUM_MODES-1:0] x_in;
    logic                 busy;
    logic [NUM_MODES-1:0] mode;
    logic [NUM_MODES-1:0] mode_led;
    logic                 mode_valid;
    logic                 mode_change;
    logic                 pending;
    logic                 error;
    logic [1:0]           state;

    modport master (
        output x_in, busy,
        input  mode, mode_led, mode_valid, mode_change, pending, error, state
    );

    modport slave (
        input  x_in, busy,
        output mode, mode_led, mode_valid, mode_change, pending, error, state
    );
endinterface

// File: rtl/mode_select_fsm.sv
// Debounced one-hot mode selector with busy-deferred commits and invalid-input recovery.
// Optional feature macro: MODE_ERR_BLINK_EN (blinking all-on LEDs while in ERROR).
module mode_select_fsm #(
    parameter int NUM_MODES         = 3,
    parameter int STABLE_CYCLES     = 4,
    parameter int BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    mode_select_fsm_if.slave  bus
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        ACTIVE  = 2'b01,
        PENDING = 2'b10,
        ERROR   = 2'b11
    } state_t;

    generate
        if (NUM_MODES < 2 || STABLE_CYCLES < 1 || BLINK_HALF_PERIOD < 1) begin : g_bad_params
            $error("mode_select_fsm: illegal parameter set");
        end
    endgenerate

    state_t               fsm_state;
    logic [NUM_MODES-1:0] s;
    logic [NUM_MODES-1:0] mode_r;
    logic [NUM_MODES-1:0] pend_r;
    logic [CNT_W-1:0]     cnt;
    logic                 mode_change_r;
    logic                 settled;
    logic                 is_zero;
    logic                 is_valid;
    logic                 is_multi;

    // Sampler: any change restarts the stability count at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            cnt <= '0;
        end else if (bus.x_in != s) begin
            s   <= bus.x_in;
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign settled  = (cnt == CNT_MAX);
    assign is_zero  = (s == '0);
    assign is_valid = !is_zero && ((s & (s - NUM_MODES'(1))) == '0);
    assign is_multi = !is_zero && !is_valid;

    // Mode FSM: settled MULTI outranks every state and the busy check
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state     <= NONE;
            mode_r        <= '0;
            pend_r        <= '0;
            mode_change_r <= 1'b0;
        end else begin
            mode_change_r <= 1'b0;
            if (settled && is_multi) begin
                fsm_state     <= ERROR;
                mode_r        <= '0;
                mode_change_r <= |mode_r;
            end else if (settled) begin
                case (fsm_state)
                    NONE: begin
                        if (is_valid) begin
                            mode_r        <= s;
                            mode_change_r <= 1'b1;
                            fsm_state     <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (s != mode_r) begin
                            if (!bus.busy) begin
                                mode_r        <= s;
                                mode_change_r <= 1'b1;
                                fsm_state     <= is_zero ? NONE : ACTIVE;
                            end else begin
                                pend_r    <= s;
                                fsm_state <= PENDING;
                            end
                        end
                    end
                    PENDING: begin
                        if (s == pend_r) begin
                            if (!bus.busy) begin
                                mode_r        <= pend_r;
                                mode_change_r <= 1'b1;
                                fsm_state     <= (pend_r == '0) ? NONE : ACTIVE;
                            end
                        end else if (s == mode_r) begin
                            fsm_state <= ACTIVE;
                        end else begin
                            pend_r <= s;
                        end
                    end
                    ERROR: begin
                        if (is_zero) begin
                            fsm_state <= NONE;
                        end else if (is_valid) begin
                            mode_r        <= s;
                            mode_change_r <= 1'b1;
                            fsm_state     <= ACTIVE;
                        end
                    end
                    default: fsm_state <= NONE;
                endcase
            end
        end
    end

    assign bus.mode        = mode_r;
    assign bus.mode_valid  = |mode_r;
    assign bus.mode_change = mode_change_r;
    assign bus.pending     = (fsm_state == PENDING);
    assign bus.error       = (fsm_state == ERROR);
    assign bus.state       = fsm_state;

`ifdef MODE_ERR_BLINK_EN
    localparam int                 BLINK_W    = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    // Held in reset outside ERROR so every ERROR entry starts with LEDs on
    always_ff @(posedge clk) begin
        if (rst || fsm_state != ERROR) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign bus.mode_led = (fsm_state == ERROR) ? {NUM_MODES{blink_on}} : mode_r;
`else
    assign bus.mode_led = mode_r;
`endif

endmodule

// File: tb/tb_mode_select_fsm.sv
// Directed bench for mode_select_fsm (NUM_MODES=3, STABLE_CYCLES=4, BLINK_HALF_PERIOD=3).
module tb_mode_select_fsm;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

`ifdef MODE_ERR_BLINK_EN
    localparam logic [2:0] ERR_LED = 3'b111;
`else
    localparam logic [2:0] ERR_LED = 3'b000;
`endif

    mode_select_fsm_if #(.NUM_MODES(3)) bus ();

    mode_select_fsm #(
        .NUM_MODES        (3),
        .STABLE_CYCLES    (4),
        .BLINK_HALF_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic [2:0] md,
                              input logic chg, input logic [2:0] led);
        check({tag, ".state"},       32'(bus.state),       32'(st));
        check({tag, ".mode"},        32'(bus.mode),        32'(md));
        check({tag, ".mode_change"}, 32'(bus.mode_change), 32'(chg));
        check({tag, ".mode_valid"},  32'(bus.mode_valid),  32'(md != 3'b000));
        check({tag, ".pending"},     32'(bus.pending),     32'(st == 2'b10));
        check({tag, ".error"},       32'(bus.error),       32'(st == 2'b11));
        check({tag, ".mode_led"},    32'(bus.mode_led),    32'(led));
    endtask

    initial begin
        logic [2:0] exp_led;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.x_in = 3'b000;
        bus.busy = 1'b0;
        tick();
        check_outs("reset", 2'b00, 3'b000, 1'b0, 3'b000);

        // First commit: latency of STABLE_CYCLES+1 edges
        rst = 1'b0;
        bus.x_in = 3'b010;
        repeat (4) tick();
        check_outs("first_before", 2'b00, 3'b000, 1'b0, 3'b000);
        tick();
        check_outs("first_commit", 2'b01, 3'b010, 1'b1, 3'b010);
        tick();
        check_outs("first_after", 2'b01, 3'b010, 1'b0, 3'b010);

        bus.x_in = 3'b001;
        repeat (5) tick();
        check_outs("to_001", 2'b01, 3'b001, 1'b1, 3'b001);

        // Three-sample glitch never reaches the FSM
        bus.x_in = 3'b100;
        repeat (3) tick();
        bus.x_in = 3'b001;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs("glitch", 2'b01, 3'b001, 1'b0, 3'b001);
        end

        // Deferred commit while busy
        bus.busy = 1'b1;
        bus.x_in = 3'b100;
        repeat (4) tick();
        check_outs("defer_unsettled", 2'b01, 3'b001, 1'b0, 3'b001);
        tick();
        check_outs("defer_pending", 2'b10, 3'b001, 1'b0, 3'b001);
        repeat (2) tick();
        check_outs("defer_hold", 2'b10, 3'b001, 1'b0, 3'b001);
        bus.busy = 1'b0;
        tick();
        check_outs("defer_commit", 2'b01, 3'b100, 1'b1, 3'b100);

        // Cancel a pending change by returning to the committed mode
        bus.x_in = 3'b001;
        repeat (5) tick();
        check_outs("cancel_setup", 2'b01, 3'b001, 1'b1, 3'b001);
        bus.busy = 1'b1;
        bus.x_in = 3'b100;
        repeat (5) tick();
        check_outs("cancel_pending", 2'b10, 3'b001, 1'b0, 3'b001);
        bus.x_in = 3'b001;
        repeat (4) tick();
        check_outs("cancel_unsettled", 2'b10, 3'b001, 1'b0, 3'b001);
        tick();
        check_outs("cancel_done", 2'b01, 3'b001, 1'b0, 3'b001);

        // Retarget a pending change to ZERO, then commit it
        bus.x_in = 3'b100;
        repeat (5) tick();
        check_outs("retarget_pending", 2'b10, 3'b001, 1'b0, 3'b001);
        bus.x_in = 3'b000;
        repeat (5) tick();
        check_outs("retarget_zero", 2'b10, 3'b001, 1'b0, 3'b001);
        bus.busy = 1'b0;
        tick();
        check_outs("commit_zero", 2'b00, 3'b000, 1'b1, 3'b000);
        tick();
        check_outs("none_hold", 2'b00, 3'b000, 1'b0, 3'b000);

        // MULTI while busy forces ERROR and clears the mode
        bus.x_in = 3'b001;
        repeat (5) tick();
        check_outs("err_setup", 2'b01, 3'b001, 1'b1, 3'b001);
        bus.busy = 1'b1;
        bus.x_in = 3'b011;
        repeat (4) tick();
        check_outs("err_unsettled", 2'b01, 3'b001, 1'b0, 3'b001);
        tick();
        check_outs("err_entry", 2'b11, 3'b000, 1'b1, ERR_LED);
        tick();
        check_outs("err_hold", 2'b11, 3'b000, 1'b0, ERR_LED);
        bus.x_in = 3'b100;
        repeat (5) tick();
        check_outs("err_recover", 2'b01, 3'b100, 1'b1, 3'b100);

        // LED behaviour across an ERROR episode
        bus.busy = 1'b0;
        bus.x_in = 3'b110;
        repeat (5) tick();
        check_outs("blink_entry", 2'b11, 3'b000, 1'b1, ERR_LED);
        for (int k = 1; k < 7; k++) begin
            tick();
`ifdef MODE_ERR_BLINK_EN
            exp_led = (((k / 3) % 2) == 0) ? 3'b111 : 3'b000;
`else
            exp_led = 3'b000;
`endif
            check("blink_led", 32'(bus.mode_led), 32'(exp_led));
        end

        // Reset in the middle of ERROR
        rst = 1'b1;
        bus.x_in = 3'b000;
        tick();
        check_outs("rst_mid_error", 2'b00, 3'b000, 1'b0, 3'b000);
        rst = 1'b0;

        // ERROR entered from NONE (no mode change), then left via ZERO
        bus.x_in = 3'b110;
        repeat (5) tick();
        check_outs("err_from_none", 2'b11, 3'b000, 1'b0, ERR_LED);
        bus.x_in = 3'b000;
        repeat (4) tick();
        check_outs("err_zero_unsettled", 2'b11, 3'b000, 1'b0, ERR_LED);
        tick();
        check_outs("err_to_none", 2'b00, 3'b000, 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
